wishbone_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one Wishbone classic slave port among `NUM_MASTERS` Wishbone masters, for example the AXI-to-Wishbone bridge and the controller's debug/programming engine. Each master holds ownership for as long as it keeps `CYC` asserted, so locked sequences of transfers are supported. A per-transfer watchdog terminates hung slave cycles with an error to the owning master. The arbiter sits between the bridges/masters and the shared memory/peripheral interconnect.

---
 rtl/wishbone_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_MASTERS masters share one slave port.
// The owner keeps the bus while it holds CYC, which allows locked sequences.
// A per-transfer watchdog aborts a hung slave cycle and reports ERR to the owner.
module wishbone_rr_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTERS-1:0]              M_CYC,
    input  logic [NUM_MASTERS-1:0]              M_STB,
    input  logic [NUM_MASTERS-1:0]              M_WE,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   M_ADDR,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   M_WDATA,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] M_SEL,
    output logic [DATA_WIDTH-1:0]               M_RDATA,
    output logic [NUM_MASTERS-1:0]              M_ACK,
    output logic [NUM_MASTERS-1:0]              M_ERR,
    output logic [NUM_MASTERS-1:0]              GRANT,
    output logic                                WB_CYC,
    output logic                                WB_STB,
    output logic                                WB_WE,
    output logic [ADDR_WIDTH-1:0]               WB_ADDR,
    output logic [DATA_WIDTH-1:0]               WB_WDATA,
    output logic [DATA_WIDTH/8-1:0]             WB_SEL,
    input  logic [DATA_WIDTH-1:0]               WB_RDATA,
    input  logic                                WB_ACK
);

    localparam int SEL_W   = DATA_WIDTH / 8;
    localparam int IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WD_TERM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ERROR
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  owner, owner_nx;
    logic [IDX_W-1:0]  rr_ptr, rr_nx;
    logic [WD_W-1:0]   wd_cnt;

    logic              req_found;
    logic [IDX_W-1:0]  req_idx;

    logic [NUM_MASTERS-1:0] own_oh;
    logic                   own_cyc, own_stb, own_we;
    logic [ADDR_WIDTH-1:0]  own_addr;
    logic [DATA_WIDTH-1:0]  own_wdata;
    logic [SEL_W-1:0]       own_sel;
    logic                   stb_live;
    logic                   wd_hit;

    // Read data is a plain broadcast; masters qualify it with their own ACK.
    assign M_RDATA = WB_RDATA;

    // Round-robin pick: first requester at or above rr_ptr, else first one below it.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!req_found && M_CYC[i] && (IDX_W'(i) >= rr_ptr)) begin
                req_found = 1'b1;
                req_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!req_found && M_CYC[i]) begin
                req_found = 1'b1;
                req_idx   = IDX_W'(i);
            end
        end
    end

    // Select the owner's request signals out of the packed master buses.
    always_comb begin
        own_oh    = '0;
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        own_sel   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IDX_W'(i)) begin
                own_oh[i] = 1'b1;
                own_cyc   = M_CYC[i];
                own_stb   = M_STB[i];
                own_we    = M_WE[i];
                own_addr  = M_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_wdata = M_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                own_sel   = M_SEL[i*SEL_W +: SEL_W];
            end
        end
    end

    // A strobe is live on the slave only while BUSY and the owner holds CYC.
    assign stb_live = (state == ST_BUSY) && own_cyc && own_stb;
    // An ACK on the terminal-count cycle wins over the timeout.
    assign wd_hit   = (TIMEOUT_CYCLES != 0) && stb_live && !WB_ACK &&
                      (wd_cnt == WD_W'(WD_TERM));

    // Slave-side and master-side outputs decoded from the current state.
    always_comb begin
        WB_CYC   = 1'b0;
        WB_STB   = 1'b0;
        WB_WE    = 1'b0;
        WB_ADDR  = '0;
        WB_WDATA = '0;
        WB_SEL   = '0;
        GRANT    = '0;
        M_ACK    = '0;
        M_ERR    = '0;
        case (state)
            ST_BUSY: begin
                WB_CYC   = own_cyc;
                WB_STB   = own_cyc && own_stb;
                WB_WE    = own_we;
                WB_ADDR  = own_addr;
                WB_WDATA = own_wdata;
                WB_SEL   = own_sel;
                GRANT    = own_oh;
                M_ACK    = own_oh & {NUM_MASTERS{WB_ACK}};
            end
            ST_ERROR: begin
                // CYC/STB low for this cycle aborts the hung slave access.
                WB_WE    = own_we;
                WB_ADDR  = own_addr;
                WB_WDATA = own_wdata;
                WB_SEL   = own_sel;
                GRANT    = own_oh;
                M_ERR    = own_oh;
            end
            default: ;
        endcase
    end

    // Next-state logic: arbitrate in IDLE, hold ownership until CYC drops.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (req_found) begin
                    owner_nx = req_idx;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!own_cyc) begin
                    state_nx = ST_IDLE;
                    rr_nx    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end else if (wd_hit) begin
                    state_nx = ST_ERROR;
                end
            end
            ST_ERROR: state_nx = ST_BUSY;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_nx;
        end
    end

    // Watchdog: counts consecutive un-ACKed strobe cycles, saturating.
    always_ff @(posedge clk) begin
        if (rst || !stb_live || WB_ACK) begin
            wd_cnt <= '0;
        end else if (wd_cnt != {WD_W{1'b1}}) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter: 2 masters, 8-cycle watchdog.
module tb_wishbone_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NM = 2;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM*DW/8-1:0] m_sel;
    logic [DW-1:0]     m_rdata;
    logic [NM-1:0]     m_ack, m_err, grant;
    logic              wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_wdata;
    logic [DW/8-1:0]   wb_sel;
    logic [DW-1:0]     wb_rdata;
    logic              wb_ack;

    int n_tests = 0;
    int n_fail  = 0;

    wishbone_rr_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .M_CYC(m_cyc), .M_STB(m_stb), .M_WE(m_we),
        .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_SEL(m_sel),
        .M_RDATA(m_rdata), .M_ACK(m_ack), .M_ERR(m_err), .GRANT(grant),
        .WB_CYC(wb_cyc), .WB_STB(wb_stb), .WB_WE(wb_we),
        .WB_ADDR(wb_addr), .WB_WDATA(wb_wdata), .WB_SEL(wb_sel),
        .WB_RDATA(wb_rdata), .WB_ACK(wb_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_sel    = '0;
        wb_ack   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        wb_rdata = 32'h1234_5678;
        do_reset();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_wbcyc", {wb_cyc, wb_stb, wb_we}, 0);
        chk("rst_ack_err", {m_ack, m_err}, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_rdata", m_rdata, 32'h1234_5678);

        // Single read by master 1
        m_cyc = 2'b10; m_stb = 2'b10; m_addr[AW +: AW] = 32'h100; m_sel = 8'hF0;
        #1;
        chk("rd_grant_pre", grant, 0);
        tick();
        chk("rd_grant", grant, 2'b10);
        chk("rd_wbctl", {wb_cyc, wb_stb, wb_we}, 3'b110);
        chk("rd_addr", wb_addr, 32'h100);
        chk("rd_sel", wb_sel, 4'hF);
        chk("rd_noack", m_ack, 0);
        tick();
        wb_ack = 1'b1; wb_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_ack", m_ack, 2'b10);
        chk("rd_rdata", m_rdata, 32'hDEAD_BEEF);
        tick();
        wb_ack = 1'b0; m_cyc = '0; m_stb = '0;
        #1;
        chk("rd_ack_once", m_ack, 0);
        tick();
        chk("rd_release", grant, 0);

        // Contention from reset: master 0 first, one dead cycle on handover
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        m_addr = {32'h300, 32'h200};
        tick();
        chk("ct_grant0", grant, 2'b01);
        chk("ct_addr0", wb_addr, 32'h200);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        chk("ct_drop_gate", {wb_cyc, wb_stb}, 0);
        chk("ct_no_preempt", grant, 2'b01);
        tick();
        chk("ct_dead_grant", grant, 0);
        chk("ct_dead_cyc", wb_cyc, 0);
        tick();
        chk("ct_grant1", grant, 2'b10);
        chk("ct_addr1", {wb_cyc, wb_addr}, {1'b1, 32'h300});
        m_cyc = '0; m_stb = '0;
        tick();

        // Fairness: released owner re-requests at once; expect 0,1,0,1
        m_cyc = 2'b11;
        for (int r = 0; r < 4; r++) begin
            int w;
            int e;
            e = r % 2;
            w = 0;
            while (grant == 0 && w < 8) begin
                tick();
                w++;
            end
            chk($sformatf("fair_grant%0d", r), grant, 64'(1) << e);
            m_cyc[e] = 1'b0;
            tick();
            m_cyc[e] = 1'b1;
        end
        m_cyc = '0;
        tick();

        // Locked burst: master 0 keeps CYC for 3 writes, master 1 waits
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b01; m_we = 2'b01; m_sel = 8'h0F;
        m_addr[AW +: AW] = 32'h999;
        tick();
        for (int k = 0; k < 3; k++) begin
            m_addr[0 +: AW]  = 32'h10 + 32'(4 * k);
            m_wdata[0 +: DW] = 32'hA000_0000 + 32'(k);
            #1;
            chk($sformatf("bur_addr%0d", k), wb_addr, 32'h10 + 32'(4 * k));
            chk($sformatf("bur_wdata%0d", k), {wb_we, wb_wdata}, {1'b1, 32'hA000_0000 + 32'(k)});
            wb_ack = 1'b1;
            #1;
            chk($sformatf("bur_ack%0d", k), m_ack, 2'b01);
            chk($sformatf("bur_grant%0d", k), grant, 2'b01);
            tick();
            wb_ack = 1'b0; m_stb[0] = 1'b0;
            #1;
            chk($sformatf("bur_gap%0d", k), {m_ack, wb_stb, grant}, {2'b00, 1'b0, 2'b01});
            tick();
            m_stb[0] = 1'b1;
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        chk("bur_dead", grant, 0);
        tick();
        chk("bur_next", grant, 2'b10);
        m_cyc = '0;
        tick();

        // Timeout: strobe held, no ACK for 8 cycles
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_addr[0 +: AW] = 32'h40;
        tick();
        for (int i = 0; i < TO; i++) begin
            chk($sformatf("to_wait%0d", i), {m_err, wb_cyc}, {2'b00, 1'b1});
            tick();
        end
        wb_ack = 1'b1;  // stray ACK during ERROR must not be forwarded
        #1;
        chk("to_err", m_err, 2'b01);
        chk("to_abort", {wb_cyc, wb_stb}, 0);
        chk("to_noack", m_ack, 0);
        tick();
        wb_ack = 1'b0;
        #1;
        chk("to_keep", {grant, wb_cyc, m_err}, {2'b01, 1'b1, 2'b00});
        // ACK on the terminal-count cycle wins over the timeout
        repeat (TO - 1) tick();
        wb_ack = 1'b1;
        #1;
        chk("to_ack_wins", {m_ack, m_err}, {2'b01, 2'b00});
        tick();
        wb_ack = 1'b0;
        #1;
        chk("to_no_err", {m_err, wb_cyc}, {2'b00, 1'b1});
        m_cyc = '0; m_stb = '0;
        tick();
        chk("to_release", grant, 0);

        // Reset mid-transaction clears pending ACK and rr_ptr
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        m_cyc = '0; m_stb = '0;
        tick();
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        chk("mr_grant1", {grant, wb_cyc}, {2'b10, 1'b1});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; wb_ack = 1'b1; m_cyc = 2'b11; m_stb = 2'b00;
        #1;
        chk("mr_grant0", grant, 0);
        chk("mr_cyc", {wb_cyc, wb_stb}, 0);
        chk("mr_late_ack", {m_ack, m_err}, 0);
        tick();
        chk("mr_rrptr", grant, 2'b01);
        wb_ack = 1'b0; m_cyc = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
